// File: rtl/draw_pkg.sv
// Shared types and constants for the frame draw scheduler and its pixel pipeline.
package draw_pkg;
  localparam int COLOR_W   = 7;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int FB_ADDR_W = 17;
  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam logic [COLOR_W-1:0] TRANSPARENT = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } sched_state_e;

  // Row-major word address for a 320-wide surface: Y*256 + Y*64 + X.
  function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                      input logic [Y_W-1:0] y);
    logic [FB_ADDR_W-1:0] yy;
    logic [FB_ADDR_W-1:0] xx;
    yy = {{(FB_ADDR_W-Y_W){1'b0}}, y};
    xx = {{(FB_ADDR_W-X_W){1'b0}}, x};
    return (yy << 8) + (yy << 6) + xx;
  endfunction
endpackage

// File: rtl/draw_scheduler_pixel_stage.sv
// Per-pixel clip/transparency filter, address generation and the framebuffer write register.
module pixel_stage
  import draw_pkg::*;
#(
  parameter int                 SCREEN_W    = draw_pkg::SCREEN_W,
  parameter int                 SCREEN_H    = draw_pkg::SCREEN_H,
  parameter logic [COLOR_W-1:0] TRANSPARENT = draw_pkg::TRANSPARENT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [X_W-1:0]       x,
  input  logic [Y_W-1:0]       y,
  input  logic [COLOR_W-1:0]   color,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data
);
  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);

  logic                 accept_s;
  logic [FB_ADDR_W-1:0] addr_s;

  // Accept decision and address for the candidate pixel.
  always_comb begin
    accept_s = 1'b0;
    addr_s   = pixel_addr(x, y);
    if (valid && (color != TRANSPARENT) && (x < X_LIM) && (y < Y_LIM)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Output register; reset also cancels a write still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= accept_s;
      if (accept_s) begin
        fb_addr <= addr_s;
        fb_data <= color;
      end
    end
  end
endmodule

// File: rtl/draw_scheduler.sv
// Frame-level scheduler: launches drawing clients in turn, forwards their pixels to the
// pixel stage, guards each client with a watchdog and manages double-buffer flags.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int                 NUM_CLIENTS = 4,
  parameter int                 SCREEN_W    = draw_pkg::SCREEN_W,
  parameter int                 SCREEN_H    = draw_pkg::SCREEN_H,
  parameter logic [COLOR_W-1:0] TRANSPARENT = draw_pkg::TRANSPARENT,
  parameter int                 TIMEOUT     = 131072
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                frame_start,
  input  logic [NUM_CLIENTS-1:0][X_W-1:0]     client_X,
  input  logic [NUM_CLIENTS-1:0][Y_W-1:0]     client_Y,
  input  logic [NUM_CLIENTS-1:0][COLOR_W-1:0] client_color,
  input  logic [NUM_CLIENTS-1:0]              client_done,
  output logic [NUM_CLIENTS-1:0]              client_start,
  output logic [FB_ADDR_W-1:0]                fb_addr,
  output logic [COLOR_W-1:0]                  fb_data,
  output logic                                fb_we,
  output logic                                draw_buf,
  output logic                                disp_buf,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                overrun,
  output logic                                timeout_err
);
  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
  localparam logic [WD_W-1:0]        WD_LIMIT = WD_W'(TIMEOUT - 1);
  localparam logic [NUM_CLIENTS-1:0] ONE_HOT0 = NUM_CLIENTS'(1);

  sched_state_e     state_r;
  logic [IDX_W-1:0] idx_r;
  logic [WD_W-1:0]  wd_r;
  logic             swap_pending_r;
  logic             draw_buf_r;

  logic               sel_done_s;
  logic               wd_hit_s;
  logic               pix_valid_s;
  logic [X_W-1:0]     sel_x_s;
  logic [Y_W-1:0]     sel_y_s;
  logic [COLOR_W-1:0] sel_color_s;

  // Select the active client's lane; other clients' done lines are never looked at.
  always_comb begin
    sel_x_s     = client_X[idx_r];
    sel_y_s     = client_Y[idx_r];
    sel_color_s = client_color[idx_r];
    sel_done_s  = client_done[idx_r];
    wd_hit_s    = (state_r == ST_RUN) && (wd_r == WD_LIMIT);
    pix_valid_s = (state_r == ST_RUN) && !sel_done_s && !wd_hit_s;
  end

  // Scheduler FSM with registered strobes and buffer flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      idx_r          <= '0;
      wd_r           <= '0;
      swap_pending_r <= 1'b0;
      draw_buf_r     <= 1'b0;
      client_start   <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      overrun        <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      client_start <= '0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= frame_start && (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            if (swap_pending_r) begin
              draw_buf_r <= ~draw_buf_r;
            end
            swap_pending_r <= 1'b0;
            idx_r          <= '0;
            client_start   <= ONE_HOT0;
            busy           <= 1'b1;
            state_r        <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wd_r    <= '0;
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          wd_r <= wd_r + WD_W'(1);
          if (sel_done_s || wd_hit_s) begin
            // A done arriving on the watchdog's last cycle counts as a normal completion.
            timeout_err <= wd_hit_s && !sel_done_s;
            if (idx_r == LAST_IDX) begin
              frame_done <= 1'b1;
              state_r    <= ST_FINISH;
            end else begin
              idx_r        <= idx_r + IDX_W'(1);
              client_start <= ONE_HOT0 << (idx_r + IDX_W'(1));
              state_r      <= ST_LAUNCH;
            end
          end
        end
        ST_FINISH: begin
          swap_pending_r <= 1'b1;
          busy           <= 1'b0;
          state_r        <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign draw_buf = draw_buf_r;
  assign disp_buf = ~draw_buf_r;

  pixel_stage #(
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H),
    .TRANSPARENT(TRANSPARENT)
  ) u_pixel_stage (
    .clk    (clk),
    .reset  (reset),
    .valid  (pix_valid_s),
    .x      (sel_x_s),
    .y      (sel_y_s),
    .color  (sel_color_s),
    .fb_we  (fb_we),
    .fb_addr(fb_addr),
    .fb_data(fb_data)
  );
endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench: per-frame schedule and write list are derived from client programs.
module tb_draw_scheduler;
  localparam int NC   = 3;
  localparam int TO   = 64;
  localparam int MAXP = 70;

  logic                clk = 1'b0;
  logic                reset;
  logic                frame_start;
  logic [NC-1:0][8:0]  client_X;
  logic [NC-1:0][7:0]  client_Y;
  logic [NC-1:0][6:0]  client_color;
  logic [NC-1:0]       client_done;
  logic [NC-1:0]       client_start;
  logic [16:0]         fb_addr;
  logic [6:0]          fb_data;
  logic                fb_we, draw_buf, disp_buf, busy, frame_done, overrun, timeout_err;

  always #5 clk = ~clk;

  draw_scheduler #(.NUM_CLIENTS(NC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .client_X(client_X), .client_Y(client_Y), .client_color(client_color),
    .client_done(client_done), .client_start(client_start),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .draw_buf(draw_buf), .disp_buf(disp_buf), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
  );

  typedef struct { int due; int addr; int data; } wr_t;
  wr_t wq[$];

  int vectors = 0;
  int miscompares = 0;
  int writes_seen;
  int px_x[NC][MAXP], px_y[NC][MAXP], px_c[NC][MAXP];
  int np[NC];
  bit to_c[NC];
  bit m_db = 1'b0, m_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit visible(input int x, input int y, input int c);
    return (c != 127) && (x < 320) && (y < 240);
  endfunction

  task automatic set_px(input int i, input int k, input int x, input int y, input int c);
    px_x[i][k] = x; px_y[i][k] = y; px_c[i][k] = c;
  endtask

  task automatic prog_visible(input int i, input int n);
    np[i] = n; to_c[i] = 1'b0;
    for (int k = 0; k < n; k++)
      set_px(i, k, $urandom_range(0, 319), $urandom_range(0, 239), $urandom_range(0, 126));
  endtask

  task automatic prog_random(input int i, input int n);
    np[i] = n; to_c[i] = 1'b0;
    for (int k = 0; k < n; k++)
      set_px(i, k, $urandom_range(0, 511), $urandom_range(0, 255),
             ($urandom_range(0, 3) == 0) ? 127 : $urandom_range(0, 127));
  endtask

  // One frame: frame_start at r=0, optional overrun injections and optional reset.
  task automatic run_frame(input int inj1, input bit inj_fin, input int rst_at);
    int st[NC], en[NC];
    int fin, last, inj2, k;
    bit new_db, exp_db, rst_done, exp_to;
    logic [NC-1:0] exp_cs;
    st[0] = 1;
    for (int i = 0; i < NC; i++) begin
      en[i] = st[i] + (to_c[i] ? TO : np[i] + 1);
      if (i < NC - 1) st[i+1] = en[i] + 1;
    end
    fin  = en[NC-1] + 1;
    inj2 = inj_fin ? fin : -1;
    last = (rst_at >= 0) ? rst_at + 3 : fin + 2;
    new_db = m_pend ? ~m_db : m_db;
    writes_seen = 0;
    for (int r = 0; r <= last; r++) begin
      @(negedge clk);
      rst_done = (rst_at >= 0) && (r > rst_at);
      if (rst_done) begin
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_data", 32'(fb_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_client_start", 32'(client_start), 32'd0);
        chk("rst_pulses", 32'({frame_done, overrun, timeout_err}), 32'd0);
        chk("rst_draw_buf", 32'(draw_buf), 32'd0);
        chk("rst_disp_buf", 32'(disp_buf), 32'd1);
      end else begin
        exp_cs = '0;
        exp_to = 1'b0;
        for (int i = 0; i < NC; i++) begin
          if (r == st[i]) exp_cs[i] = 1'b1;
          if (to_c[i] && r == en[i] + 1) exp_to = 1'b1;
        end
        exp_db = (r >= 1) ? new_db : m_db;
        chk("client_start", 32'(client_start), 32'(exp_cs));
        chk("busy", 32'(busy), 32'(r >= st[0] && r <= fin));
        chk("frame_done", 32'(frame_done), 32'(r == fin));
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
        chk("overrun", 32'(overrun), 32'((inj1 >= 0 && r == inj1 + 1) || (inj2 >= 0 && r == inj2 + 1)));
        chk("draw_buf", 32'(draw_buf), 32'(exp_db));
        chk("disp_buf", 32'(disp_buf), 32'(!exp_db));
        if (wq.size() > 0 && wq[0].due == r) begin
          chk("fb_we", 32'(fb_we), 32'd1);
          chk("fb_addr", 32'(fb_addr), 32'(wq[0].addr));
          chk("fb_data", 32'(fb_data), 32'(wq[0].data));
          void'(wq.pop_front());
          writes_seen++;
        end else begin
          chk("fb_we_idle", 32'(fb_we), 32'd0);
        end
      end
      // drive inputs for cycle r
      frame_start = !rst_done && ((r == 0) || (r == inj1) || (r == inj2));
      reset = (r == rst_at);
      for (int i = 0; i < NC; i++) begin
        client_X[i]     = 9'($urandom);
        client_Y[i]     = 8'($urandom);
        client_color[i] = 7'($urandom);
        client_done[i]  = 1'($urandom_range(0, 1));
        if (!rst_done && r >= st[i] && r <= en[i]) begin
          client_done[i] = (r == en[i]) && !to_c[i];
          if (r > st[i] && r <= st[i] + np[i]) begin
            k = r - st[i] - 1;
            client_X[i]     = 9'(px_x[i][k]);
            client_Y[i]     = 8'(px_y[i][k]);
            client_color[i] = 7'(px_c[i][k]);
            if (r < en[i] && visible(px_x[i][k], px_y[i][k], px_c[i][k]))
              wq.push_back('{due: r + 1, addr: px_y[i][k] * 320 + px_x[i][k], data: px_c[i][k]});
          end
        end
      end
    end
    if (rst_at >= 0) begin
      m_db = 1'b0; m_pend = 1'b0; wq.delete();
    end else begin
      m_db = new_db; m_pend = 1'b1;
    end
    chk("writes_drained", 32'(wq.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0;
    client_X = '0; client_Y = '0; client_color = '0; client_done = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_fb_we", 32'(fb_we), 32'd0);
      chk("reset_fb_addr", 32'(fb_addr), 32'd0);
      chk("reset_client_start", 32'(client_start), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_draw_buf", 32'(draw_buf), 32'd0);
      chk("reset_pulses", 32'({frame_done, overrun, timeout_err}), 32'd0);
    end
    reset = 1'b0;

    // Three clients, four pixels each.
    for (int i = 0; i < NC; i++) prog_visible(i, 4);
    run_frame(-1, 1'b0, -1);
    chk("frame_a_writes", 32'(writes_seen), 32'd12);

    // Clipping edges, transparency and address arithmetic; client 2 finishes immediately.
    np[0] = 4; to_c[0] = 1'b0;
    set_px(0, 0, 319, 239, 5); set_px(0, 1, 320, 0, 5);
    set_px(0, 2, 0, 240, 5);   set_px(0, 3, 10, 10, 127);
    np[1] = 1; to_c[1] = 1'b0; set_px(1, 0, 3, 2, 9);
    np[2] = 0; to_c[2] = 1'b0;
    run_frame(-1, 1'b0, -1);
    chk("frame_b_writes", 32'(writes_seen), 32'd2);

    // Client 1 hangs and is aborted by the watchdog.
    prog_visible(0, 2);
    np[1] = TO; to_c[1] = 1'b1;
    for (int k = 0; k < TO; k++)
      set_px(1, k, $urandom_range(0, 319), $urandom_range(0, 239),
             (k < 5) ? $urandom_range(0, 126) : 127);
    prog_visible(2, 2);
    run_frame(-1, 1'b0, -1);
    chk("frame_c_writes", 32'(writes_seen), 32'd9);

    // frame_start during client 1's RUN and again coincident with FINISH.
    for (int i = 0; i < NC; i++) prog_visible(i, 3);
    run_frame(8, 1'b1, -1);

    // Randomised frames with out-of-range and transparent pixels.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NC; i++) prog_random(i, $urandom_range(0, 6));
      run_frame(-1, 1'b0, -1);
    end

    // Reset while client 1 has a pixel in flight, then a normal frame to recover.
    for (int i = 0; i < NC; i++) prog_visible(i, 4);
    run_frame(-1, 1'b0, 9);
    for (int i = 0; i < NC; i++) prog_random(i, $urandom_range(1, 5));
    run_frame(-1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
